// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: generates one Mastermind board background frame on request
// and streams it in raster order (x fastest) into the SDRAM write FIFO.
module lcd_frame_writer #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CELL_W   = 100,
  parameter int unsigned CELL_H   = 96,
  parameter int unsigned PEG_ROW  = 4,
  parameter logic [23:0] BG_RGB   = 24'h202020,
  parameter logic [23:0] PEG_RGB  = 24'h404040,
  parameter logic [23:0] LINE_RGB = 24'hC0C0C0
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSTART,
  input  logic        iWR_FULL,
  output logic        oWR_EN,
  output logic [15:0] oWR_DATA1,
  output logic [15:0] oWR_DATA2,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [10:0] XC_LAST = 11'(CELL_W - 1);
  localparam logic [9:0]  YC_LAST = 10'(CELL_H - 1);
  localparam logic [9:0]  PEG_R   = 10'(PEG_ROW);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state;
  logic [10:0] x;
  logic [10:0] xCell;
  logic [9:0]  y;
  logic [9:0]  yCell;
  logic [9:0]  cellRow;
  logic        xfer;
  logic        lineEnd;
  logic        frameEnd;
  logic [23:0] rgb;

  assign xfer     = (state == FILL) && !iWR_FULL;
  assign lineEnd  = (x == X_LAST);
  assign frameEnd = lineEnd && (y == Y_LAST);
  assign oWR_EN   = xfer;

  // Pixel colour from the cell-relative counters: grid lines win over area fill.
  always_comb begin
    rgb = BG_RGB;
    if (xCell == '0 || yCell == '0) begin
      rgb = LINE_RGB;
    end else if (cellRow >= PEG_R) begin
      rgb = PEG_RGB;
    end
  end

  assign oWR_DATA1 = rgb[23:8];
  assign oWR_DATA2 = {8'h00, rgb[7:0]};

  // Frame FSM and raster counters; counters only move on a transfer cycle.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state   <= IDLE;
      x       <= '0;
      xCell   <= '0;
      y       <= '0;
      yCell   <= '0;
      cellRow <= '0;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oDONE <= 1'b0;
          if (iSTART) begin
            state <= FILL;
            oBUSY <= 1'b1;
          end
        end
        FILL: begin
          if (xfer) begin
            // Last pixel clears everything here so y never reaches V_ACTIVE.
            if (frameEnd) begin
              state   <= DONE;
              oBUSY   <= 1'b0;
              oDONE   <= 1'b1;
              x       <= '0;
              xCell   <= '0;
              y       <= '0;
              yCell   <= '0;
              cellRow <= '0;
            end else if (lineEnd) begin
              x     <= '0;
              xCell <= '0;
              y     <= y + 10'd1;
              if (yCell == YC_LAST) begin
                yCell   <= '0;
                cellRow <= cellRow + 10'd1;
              end else begin
                yCell <= yCell + 10'd1;
              end
            end else begin
              x     <= x + 11'd1;
              xCell <= (xCell == XC_LAST) ? '0 : xCell + 11'd1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          oDONE   <= 1'b0;
          oBUSY   <= 1'b0;
          x       <= '0;
          xCell   <= '0;
          y       <= '0;
          yCell   <= '0;
          cellRow <= '0;
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
          oDONE <= 1'b0;
        end
      endcase
    end
  end

endmodule
